seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Parametrised N-digit seven-segment anode scanner; successor to the fixed 4-digit controller.
//  Selects one of N_SRC digit sources, time-multiplexes nibbles onto shared num/other lines.
//  Adds a guard gap between digits, frame-aligned source switching, blanking and blink.
//  Sits between game/timer logic and the hex-to-segment decoder.
// PARAMETERS
//  N_DIGITS     4       digits scanned; digit 0 = rightmost = an[0]
//  N_SRC        4       selectable display sources
//  DIV          100000  clk cycles per digit slot (tick period); must be > GUARD+1
//  GUARD        2       clk cycles all anodes off at each slot start; 0 = no gap
//  BLINK_FRAMES 64      full frames per blink half-period
// PORTS
//  clk          in   1              system clock
//  rst          in   1              async active-high reset
//  src_sel      in   $clog2(N_SRC)  source select
//  src_data     in   N_SRC*N_DIGITS*4  nibble [s][d] at bits ((s*N_DIGITS+d)*4)+:4
//  src_other    in   N_SRC*N_DIGITS alt-glyph flag [s][d] at bit s*N_DIGITS+d
//  blank_mask   in   N_DIGITS       1 = digit always dark
//  blink_mask   in   N_DIGITS       1 = digit dark during blink-off phase
//  blink_en     in   1              enables blinking
//  an           out  N_DIGITS       anodes, active low
//  num          out  4              nibble for current digit
//  other        out  1              alt-glyph flag for current digit
//  digit_idx    out  $clog2(N_DIGITS) index of digit being driven
//  frame_start  out  1              1-cycle pulse when slot 0 begins
// BEHAVIOUR
//  Reset (async, all regs): an=all 1s, num=0, other=0, digit_idx=0, frame_start=0,
//   div cnt=0, active src=0, blink phase=0 (visible), frame cnt=0.
//  Tick: div cnt 0..DIV-1, tick on cnt==DIV-1, then wraps to 0. Free-running, never stalls.
//  On tick cycle: an<=all 1s; digit_idx<=next (N_DIGITS-1 wraps to 0);
//   num/other<=data of next digit from active src (data settles during guard).
//  GUARD cycles after tick: an<=~(1<<digit_idx) unless digit dark, then all 1s.
//   GUARD=0: anode asserted on the tick cycle itself.
//  Digit dark = blank_mask[d] | (blink_en & blink_phase & blink_mask[d]).
//  num/other still driven for dark digits; only anodes suppressed.
//  Source: src_sel sampled only on tick when next digit_idx==0; held for whole frame.
//   src_sel >= N_SRC: keep previous active src.
//  Within a frame, src_data changes are shown live per slot (not frame-latched).
//  frame_start: high on the tick cycle moving digit_idx to 0.
//  Blink: frame cnt increments on frame_start; at BLINK_FRAMES-1 wraps and toggles
//   blink_phase. blink_en=0 forces visible but phase counter keeps running.
//  Mask changes take effect at next anode assertion; never mid-slot.
//  At most one anode low at any cycle; never two.
//  Reset mid-slot: anodes off immediately (async); scan restarts at digit 0.
//  First slot after reset: digit 0 driven after the first tick + GUARD.
// STRUCTURE
//  Package seg_scan_pkg: localparam ANODE_OFF-style helper, function onehot_low(idx,n),
//   nibble/flag slice functions for src_data/src_other indexing.
//  Sub-module clk_en_div (param DIV): counter + 1-cycle tick enable, clk/rst.
//  Top: slot FSM {GUARD, DRIVE}, digit pointer, source latch, blink counter.
// TESTING (bench with DIV=8, GUARD=2, BLINK_FRAMES=2, N_DIGITS=4)
//  Reset released, src0 data=4'h1,2,3,4 -> an cycles 1110,1101,1011,0111 with num 1,2,3,4;
//   an=1111 for 2 cycles each slot start; every 8 cycles new slot.
//  src_sel 0->2 asserted mid-slot 1 -> digits 2,3 still show src0; src2 from next digit 0.
//  src_sel=5 with N_SRC=4 -> active source unchanged, display unchanged.
//  blank_mask=4'b0100 -> an[2] never low; num still shows digit 2 nibble in its slot.
//  blink_en=1, blink_mask=4'b0001 -> digit 0 dark 2 frames, lit 2 frames, repeating.
//  rst pulsed mid-slot 2 -> an=1111 same cycle; after release first lit digit is 0.
//  All tests: assertion that popcount(~an)<=1 every cycle.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and index helpers for the seven-segment anode scanner.
// Anode vectors are built at a fixed maximum width and sized down by the caller.
package seg_scan_pkg;

    localparam int MAX_DIGITS = 32;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_t;

    // Active-low one-hot anode pattern; bits at or above n stay high.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input int idx, input int n);
        logic [MAX_DIGITS-1:0] v;
        v = ~(MAX_DIGITS'(1) << idx);
        v = v | ~((MAX_DIGITS'(1) << n) - MAX_DIGITS'(1));
        return v & ANODE_OFF;
    endfunction

    function automatic int nib_lsb(input int s, input int d, input int n_digits);
        return (s * n_digits + d) * 4;
    endfunction

    function automatic int flag_bit(input int s, input int d, input int n_digits);
        return s * n_digits + d;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Free-running divider producing a one-cycle enable every DIV clocks.
module clk_en_div #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit seven-segment anode scanner with guard gap, frame-aligned source
// switching, per-digit blanking and blink.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int N_SRC        = 4,
    parameter int DIV          = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(N_SRC+1)-1:0]    i_src_sel,
    input  logic [N_SRC*N_DIGITS*4-1:0]   i_src_data,
    input  logic [N_SRC*N_DIGITS-1:0]     i_src_other,
    input  logic [N_DIGITS-1:0]           i_blank_mask,
    input  logic [N_DIGITS-1:0]           i_blink_mask,
    input  logic                          i_blink_en,
    output logic [N_DIGITS-1:0]           o_an,
    output logic [3:0]                    o_num,
    output logic                          o_other,
    output logic [$clog2(N_DIGITS)-1:0]   o_digit_idx,
    output logic                          o_frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int SEL_W = $clog2(N_SRC + 1);
    localparam int SRC_W = $clog2(N_SRC);
    localparam int GC_W  = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    genvar gi, gj;

    logic [3:0] w_nib  [N_SRC][N_DIGITS];
    logic       w_flag [N_SRC][N_DIGITS];

    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            for (gj = 0; gj < N_DIGITS; gj++) begin : g_dig
                assign w_nib[gi][gj]  = i_src_data[nib_lsb(gi, gj, N_DIGITS) +: 4];
                assign w_flag[gi][gj] = i_src_other[flag_bit(gi, gj, N_DIGITS)];
            end
        end
    endgenerate

    slot_state_t          r_state, w_state_next;
    logic [GC_W-1:0]      r_gcnt, w_gcnt_next;
    logic [N_DIGITS-1:0]  r_an, w_an_next;
    logic [IDX_W-1:0]     r_digit_idx, w_idx_next;
    logic [3:0]           r_num, w_num_next;
    logic                 r_other, w_other_next;
    logic                 r_fs, w_fs_next;
    logic [SRC_W-1:0]     r_src, w_src_next;
    logic                 r_started, w_started_next;
    logic [FC_W-1:0]      r_fcnt, w_fcnt_next;
    logic                 r_phase, w_phase_next;

    logic                 w_tick;
    logic [IDX_W-1:0]     w_next_idx;
    logic                 w_frame;
    logic                 w_sel_valid;
    logic [SRC_W-1:0]     w_src_eff;

    clk_en_div #(.DIV(DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // The very first tick after reset lands on digit 0 rather than advancing.
    assign w_next_idx  = !r_started ? '0 :
                         (r_digit_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
    assign w_frame     = w_tick && (w_next_idx == '0);
    assign w_sel_valid = ({1'b0, i_src_sel} < (SEL_W + 1)'(N_SRC));
    assign w_src_eff   = (w_frame && w_sel_valid) ? i_src_sel[SRC_W-1:0] : r_src;

    function automatic logic [N_DIGITS-1:0] anode_for(
        input logic [IDX_W-1:0]    d,
        input logic                ph,
        input logic [N_DIGITS-1:0] blank,
        input logic [N_DIGITS-1:0] blink,
        input logic                blink_en
    );
        logic dark;
        dark = blank[d] | (blink_en & ph & blink[d]);
        return dark ? '1 : N_DIGITS'(onehot_low(int'(d), N_DIGITS));
    endfunction

    always_comb begin
        w_state_next   = r_state;
        w_gcnt_next    = r_gcnt;
        w_an_next      = r_an;
        w_idx_next     = r_digit_idx;
        w_num_next     = r_num;
        w_other_next   = r_other;
        w_fs_next      = 1'b0;
        w_src_next     = r_src;
        w_started_next = r_started;
        w_fcnt_next    = r_fcnt;
        w_phase_next   = r_phase;

        if (w_tick) begin
            w_started_next = 1'b1;
            w_idx_next     = w_next_idx;
            w_src_next     = w_src_eff;
            w_num_next     = w_nib[w_src_eff][w_next_idx];
            w_other_next   = w_flag[w_src_eff][w_next_idx];
            if (w_frame) begin
                w_fs_next = 1'b1;
                if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
                    w_fcnt_next  = '0;
                    w_phase_next = ~r_phase;
                end else begin
                    w_fcnt_next = r_fcnt + 1'b1;
                end
            end
            if (GUARD == 0) begin
                w_state_next = S_DRIVE;
                w_an_next    = anode_for(w_next_idx, w_phase_next, i_blank_mask,
                                         i_blink_mask, i_blink_en);
            end else begin
                w_state_next = S_GUARD;
                w_gcnt_next  = '0;
                w_an_next    = '1;
            end
        end else if (r_state == S_GUARD) begin
            // Masks are sampled only here, so a slot never changes mid-way.
            if (r_gcnt == GC_W'(GUARD - 1)) begin
                w_state_next = S_DRIVE;
                w_an_next    = anode_for(r_digit_idx, r_phase, i_blank_mask,
                                         i_blink_mask, i_blink_en);
            end else begin
                w_gcnt_next = r_gcnt + 1'b1;
            end
        end
    end

    // Reset parks in S_DRIVE with all anodes off until the first tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_DRIVE;
            r_gcnt      <= '0;
            r_an        <= '1;
            r_digit_idx <= '0;
            r_num       <= '0;
            r_other     <= 1'b0;
            r_fs        <= 1'b0;
            r_src       <= '0;
            r_started   <= 1'b0;
            r_fcnt      <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_gcnt      <= w_gcnt_next;
            r_an        <= w_an_next;
            r_digit_idx <= w_idx_next;
            r_num       <= w_num_next;
            r_other     <= w_other_next;
            r_fs        <= w_fs_next;
            r_src       <= w_src_next;
            r_started   <= w_started_next;
            r_fcnt      <= w_fcnt_next;
            r_phase     <= w_phase_next;
        end
    end

    assign o_an          = r_an;
    assign o_num         = r_num;
    assign o_other       = r_other;
    assign o_digit_idx   = r_digit_idx;
    assign o_frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux against a slot/frame arithmetic model.
module tb_seg_scan_mux;

    localparam int N_DIGITS     = 4;
    localparam int N_SRC        = 4;
    localparam int DIV          = 8;
    localparam int GUARD        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIV * N_DIGITS;

    logic        clk;
    logic        rst;
    logic [2:0]  src_sel;
    logic [63:0] src_data;
    logic [15:0] src_other;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        blink_en;
    logic [3:0]  an;
    logic [3:0]  num;
    logic        other;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seg_scan_mux #(
        .N_DIGITS(N_DIGITS), .N_SRC(N_SRC), .DIV(DIV),
        .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_src_sel     (src_sel),
        .i_src_data    (src_data),
        .i_src_other   (src_other),
        .i_blank_mask  (blank_mask),
        .i_blink_mask  (blink_mask),
        .i_blink_en    (blink_en),
        .o_an          (an),
        .o_num         (num),
        .o_other       (other),
        .o_digit_idx   (digit_idx),
        .o_frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: slot k starts at the k-th divider wrap, shows digit k mod N,
    // lights its anode GUARD edges later; blink phase = (frames seen / BLINK_FRAMES) mod 2.
    logic [3:0] e_an    = 4'hF;
    logic [3:0] e_num   = 4'h0;
    logic       e_other = 1'b0;
    logic [1:0] e_idx   = 2'd0;
    logic       e_fs    = 1'b0;

    initial begin
        int m_cyc, m_slot, m_frames, m_src, m_digit, m_tick_cyc;
        bit phase, dark;
        m_cyc = 0; m_slot = -1; m_frames = 0; m_src = 0; m_digit = 0; m_tick_cyc = -100;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc = 0; m_slot = -1; m_frames = 0; m_src = 0; m_digit = 0; m_tick_cyc = -100;
                e_an = 4'hF; e_num = 4'h0; e_other = 1'b0; e_idx = 2'd0; e_fs = 1'b0;
            end else begin
                e_fs = 1'b0;
                if (m_cyc % DIV == DIV - 1) begin
                    m_slot++;
                    m_digit = m_slot % N_DIGITS;
                    if (m_digit == 0) begin
                        m_frames++;
                        e_fs = 1'b1;
                        if (src_sel < N_SRC) m_src = int'(src_sel);
                    end
                    e_num      = src_data[(m_src * N_DIGITS + m_digit) * 4 +: 4];
                    e_other    = src_other[m_src * N_DIGITS + m_digit];
                    e_idx      = 2'(m_digit);
                    e_an       = 4'hF;
                    m_tick_cyc = m_cyc;
                end else if (m_cyc == m_tick_cyc + GUARD) begin
                    phase = ((m_frames / BLINK_FRAMES) % 2) == 1;
                    dark  = blank_mask[m_digit] | (blink_en & phase & blink_mask[m_digit]);
                    e_an  = dark ? 4'hF : ~(4'b0001 << m_digit);
                end
                m_cyc++;
            end
        end
    end

    wire [11:0] obs = {an, num, other, digit_idx, frame_start};
    wire [11:0] exp_v = {e_an, e_num, e_other, e_idx, e_fs};

    always @(negedge clk) begin
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot an=%b required at most one low bit", an);
        end
    end

    task automatic test_reset();
        src_sel = 3'd0; src_data = '0; src_other = '0;
        blank_mask = '0; blink_mask = '0; blink_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 12'hF00) begin
            errors++;
            $display("FAIL reset got {an,num,oth,idx,fs}=%h required %h", obs, 12'hF00);
        end
    endtask

    task automatic test_basic_scan();
        int first_lit;
        first_lit = 0;
        src_data = {$urandom, $urandom};
        src_data[15:0] = 16'h4321;
        src_other = 16'($urandom);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 5 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL basic_scan n=%0d got %b required %b", n, obs, exp_v);
            end
            if (first_lit == 0 && an !== 4'hF) begin
                first_lit = n;
                checks++;
                if (an !== 4'b1110 || n != DIV + GUARD || num !== 4'h1) begin
                    errors++;
                    $display("FAIL first_lit n=%0d an=%b num=%h required n=%0d an=1110 num=1",
                             n, an, num, DIV + GUARD);
                end
            end
        end
        checks++;
        if (first_lit == 0) begin
            errors++;
            $display("FAIL first_lit no anode asserted required one");
        end
    endtask

    task automatic test_src_switch();
        bit found, seen2, seen0;
        found = 0; seen2 = 0; seen0 = 0;
        src_data[47:32] = 16'($urandom);
        for (int n = 0; n < 4 * FRAME && !found; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL src_switch_wait got %b required %b", obs, exp_v);
            end
            if (digit_idx == 2'd1 && an == 4'b1101) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL src_switch_timeout found=0 required 1");
        end
        src_sel = 3'd2;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL src_switch n=%0d got %b required %b", n, obs, exp_v);
            end
            if (!seen2 && digit_idx == 2'd2 && an == 4'b1011) begin
                seen2 = 1; checks++;
                if (num !== 4'h3) begin
                    errors++;
                    $display("FAIL src_switch_old num=%h required 3", num);
                end
            end
            if (seen2 && !seen0 && digit_idx == 2'd0 && an == 4'b1110) begin
                seen0 = 1; checks++;
                if (num !== src_data[35:32]) begin
                    errors++;
                    $display("FAIL src_switch_new num=%h required %h", num, src_data[35:32]);
                end
            end
        end
    endtask

    task automatic test_invalid_sel();
        src_sel = 3'd5;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL invalid_sel n=%0d got %b required %b", n, obs, exp_v);
            end
            if (digit_idx == 2'd0 && an == 4'b1110 && n > FRAME) begin
                checks++;
                if (num !== src_data[35:32]) begin
                    errors++;
                    $display("FAIL invalid_sel_num num=%h required %h", num, src_data[35:32]);
                end
            end
        end
    endtask

    task automatic test_blank();
        blank_mask = 4'b0100;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blank n=%0d got %b required %b", n, obs, exp_v);
            end
            if (n > DIV && digit_idx == 2'd2) begin
                checks++;
                if (an[2] !== 1'b1 || num !== src_data[43:40]) begin
                    errors++;
                    $display("FAIL blank_digit2 an=%b num=%h required an[2]=1 num=%h",
                             an, num, src_data[43:40]);
                end
            end
        end
        blank_mask = 4'b0000;
    endtask

    task automatic test_blink();
        bit found;
        int lit;
        found = 0; lit = 0;
        blink_en = 1'b1;
        blink_mask = 4'b0001;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blink_wait got %b required %b", obs, exp_v);
            end
            if (frame_start) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL blink_timeout found=0 required 1");
        end
        // Eight whole frames from a frame start: four lit frames of DIV-GUARD cycles each.
        for (int n = 0; n < 8 * FRAME; n++) begin
            if (an == 4'b1110) lit++;
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blink n=%0d got %b required %b", n, obs, exp_v);
            end
        end
        checks++;
        if (lit != 4 * (DIV - GUARD)) begin
            errors++;
            $display("FAIL blink_lit_cycles got %0d required %0d", lit, 4 * (DIV - GUARD));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random n=%0d got %b required %b", n, obs, exp_v);
            end
            case ($urandom_range(0, 11))
                0: src_data   = {$urandom, $urandom};
                1: src_other  = 16'($urandom);
                2: src_sel    = 3'($urandom_range(0, 7));
                3: blank_mask = 4'($urandom);
                4: blink_mask = 4'($urandom);
                5: blink_en   = 1'($urandom);
                default: ;
            endcase
        end
        blank_mask = '0; blink_mask = '0; blink_en = 1'b0; src_sel = 3'd0;
    endtask

    task automatic test_reset_mid();
        bit found;
        int first_lit;
        found = 0; first_lit = 0;
        for (int n = 0; n < 3 * FRAME && !found; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_wait got %b required %b", obs, exp_v);
            end
            if (digit_idx == 2'd2 && an == 4'b1011) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_timeout found=0 required 1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || digit_idx !== 2'd0 || num !== 4'h0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async an=%b idx=%0d num=%h fs=%b required 1111 0 0 0",
                     an, digit_idx, num, frame_start);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 2 * FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid n=%0d got %b required %b", n, obs, exp_v);
            end
            if (first_lit == 0 && an !== 4'hF) begin
                first_lit = n;
                checks++;
                if (an !== 4'b1110 || n != DIV + GUARD) begin
                    errors++;
                    $display("FAIL reset_mid_first n=%0d an=%b required n=%0d an=1110",
                             n, an, DIV + GUARD);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_scan();
        test_src_switch();
        test_invalid_sel();
        test_blank();
        test_blink();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
